uart_rx_sample_deser: RTL

UART_RX_SAMPLE_DESER -- requirements
Module: uart_rx_sample_deser

---
 rtl/uart_rx_sample_deser.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx_sample_deser.sv
// UART receive sampler/deserializer: per-bit 3-tap majority vote at the bit centre,
// LSB-first shift into R_Data, and start/stop/parity pulse generation.
module uart_rx_sample_deser #(
  parameter int Data_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  En,
  input  logic                  PAR_EN,
  input  logic [5:0]            Prescale,
  input  logic                  RX_IN,
  output logic                  Sampled_Bit,
  output logic                  Sample_Valid,
  output logic [3:0]            Bit_Cnt,
  output logic [Data_Width-1:0] R_Data,
  output logic                  Deser_Done,
  output logic                  Parity_In,
  output logic                  Start_Glitch,
  output logic                  Stop_Err,
  output logic                  Frame_Done
);

  localparam logic [3:0] LP_DW = 4'(Data_Width);

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      6'd8, 6'd16, 6'd32: return p;
      default:            return 6'd16;
    endcase
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic       r_en_d;
  logic       r_active;
  logic [5:0] r_p;
  logic [5:0] r_edge_cnt;
  logic       r_s0;
  logic       r_s1;
  logic       r_stop_seen;

  logic       w_rise;
  logic       w_run;
  logic [5:0] w_p;
  logic [5:0] w_half;
  logic [3:0] w_stop_idx;
  logic       w_vote;
  logic       w_fire;

  // The rising cycle must already use the new prescale, before r_p has captured it.
  assign w_rise     = En & ~r_en_d;
  assign w_run      = En & (r_active | w_rise);
  assign w_p        = w_rise ? legal_prescale(Prescale) : r_p;
  assign w_half     = {1'b0, w_p[5:1]};
  assign w_stop_idx = LP_DW + 4'd1 + {3'b000, PAR_EN};
  assign w_vote     = majority3(r_s0, r_s1, RX_IN);
  assign w_fire     = w_run & (r_edge_cnt == w_half + 6'd1) & ~r_stop_seen;

  always_ff @(posedge CLK) begin
    // Tracks En even in reset so a level held through reset is not seen as a new frame.
    r_en_d <= En;
    if (RST) begin
      r_active     <= 1'b0;
      r_p          <= 6'd16;
      r_edge_cnt   <= 6'd0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_stop_seen  <= 1'b0;
      Sampled_Bit  <= 1'b0;
      Sample_Valid <= 1'b0;
      Bit_Cnt      <= 4'd0;
      R_Data       <= '0;
      Deser_Done   <= 1'b0;
      Parity_In    <= 1'b0;
      Start_Glitch <= 1'b0;
      Stop_Err     <= 1'b0;
      Frame_Done   <= 1'b0;
    end else begin
      Sample_Valid <= 1'b0;
      Deser_Done   <= 1'b0;
      Start_Glitch <= 1'b0;
      Stop_Err     <= 1'b0;
      Frame_Done   <= 1'b0;
      r_active     <= w_run;
      if (w_rise) r_p <= legal_prescale(Prescale);
      if (!w_run) begin
        r_edge_cnt  <= 6'd0;
        Bit_Cnt     <= 4'd0;
        r_stop_seen <= 1'b0;
      end else begin
        if (r_edge_cnt == w_p - 6'd1) begin
          r_edge_cnt <= 6'd0;
          if (Bit_Cnt != w_stop_idx) Bit_Cnt <= Bit_Cnt + 4'd1;
        end else begin
          r_edge_cnt <= r_edge_cnt + 6'd1;
        end
        if (r_edge_cnt == w_half - 6'd1) r_s0 <= RX_IN;
        if (r_edge_cnt == w_half)        r_s1 <= RX_IN;
        if (w_fire) begin
          Sample_Valid <= 1'b1;
          Sampled_Bit  <= w_vote;
          if (Bit_Cnt == 4'd0) begin
            Start_Glitch <= w_vote;
          end else if (Bit_Cnt <= LP_DW) begin
            R_Data     <= {w_vote, R_Data[Data_Width-1:1]};
            Deser_Done <= (Bit_Cnt == LP_DW);
          end else if (Bit_Cnt == w_stop_idx) begin
            Frame_Done  <= 1'b1;
            Stop_Err    <= ~w_vote;
            r_stop_seen <= 1'b1;
          end else begin
            Parity_In <= w_vote;
          end
        end
      end
    end
  end

endmodule
